// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/debug sequencer.
package pipe_ctrl_pkg;

  typedef logic [4:0] reg_id_t;
  typedef logic [1:0] debug_status_t;

  localparam reg_id_t       REG_X0    = 5'd0;
  localparam debug_status_t DBG_OK    = 2'b00;
  localparam debug_status_t DBG_BREAK = 2'b01;
  localparam debug_status_t DBG_FAIL  = 2'b10;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } ctrl_state_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// RAW comparator between the Decode sources and the Exec/Mem destinations.
module hazard_detect
  import pipe_ctrl_pkg::*;
#(
  parameter bit FORWARDING = 1'b0
) (
  input  reg_id_t rs1_i,
  input  reg_id_t rs2_i,
  input  logic    rs1_used_i,
  input  logic    rs2_used_i,
  input  reg_id_t ex_rd_i,
  input  logic    ex_reg_write_i,
  input  logic    ex_mem_load_i,
  input  reg_id_t mem_rd_i,
  input  logic    mem_reg_write_i,
  output logic    hazard_o
);

  // With forwarding only a load result is still unavailable to the next instruction.
  function automatic logic src_match(reg_id_t src, logic used);
    logic m;
    if (FORWARDING) begin
      m = ex_mem_load_i && (ex_rd_i == src);
    end else begin
      m = (ex_reg_write_i && (ex_rd_i == src)) || (mem_reg_write_i && (mem_rd_i == src));
    end
    return used && (src != REG_X0) && m;
  endfunction

  always_comb begin
    hazard_o = src_match(rs1_i, rs1_used_i) || src_match(rs2_i, rs2_used_i);
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencer: hazard stalls, jump flushes, debug drain/halt and perf counters.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter bit          FORWARDING   = 1'b0,
  parameter int unsigned DRAIN_CYCLES = 2,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       dec_rs1,
  input  logic [4:0]       dec_rs2,
  input  logic             dec_rs1_used,
  input  logic             dec_rs2_used,
  input  logic [1:0]       dec_debug,
  input  logic [4:0]       ex_rd,
  input  logic             ex_reg_write,
  input  logic             ex_mem_load,
  input  logic             ex_jump_taken,
  input  logic [4:0]       mem_rd,
  input  logic             mem_reg_write,
  output logic             stall_fetch,
  output logic             stall_decode,
  output logic             bubble_exec,
  output logic             flush_fetch,
  output logic             halted,
  output logic [1:0]       halt_cause,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam int unsigned DRAIN_W = $clog2(DRAIN_CYCLES + 1);

  ctrl_state_t        state_q, state_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;
  debug_status_t      cause_q, cause_d;
  logic [CNT_W-1:0]   stall_cnt_q, flush_cnt_q;
  logic               hazard;

  hazard_detect #(.FORWARDING(FORWARDING)) u_hazard (
    .rs1_i           (dec_rs1),
    .rs2_i           (dec_rs2),
    .rs1_used_i      (dec_rs1_used),
    .rs2_used_i      (dec_rs2_used),
    .ex_rd_i         (ex_rd),
    .ex_reg_write_i  (ex_reg_write),
    .ex_mem_load_i   (ex_mem_load),
    .mem_rd_i        (mem_rd),
    .mem_reg_write_i (mem_reg_write),
    .hazard_o        (hazard)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      drain_q <= '0;
      cause_q <= DBG_OK;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      cause_q <= cause_d;
    end
  end

  // A jump in the same cycle as a debug status wins; the status is dropped.
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    cause_d = cause_q;
    case (state_q)
      ST_RUN: begin
        if ((dec_debug != DBG_OK) && !ex_jump_taken) begin
          state_d = ST_DRAIN;
          drain_d = DRAIN_W'(DRAIN_CYCLES);
          cause_d = dec_debug;
        end
      end
      ST_DRAIN: begin
        drain_d = drain_q - DRAIN_W'(1);
        if (drain_q == DRAIN_W'(1)) begin
          state_d = ST_HALTED;
        end
      end
      ST_HALTED: ;
      default: state_d = ST_RUN;
    endcase
  end

  // Outputs are held low while rst_n is asserted, whatever the pipeline presents.
  always_comb begin
    stall_fetch  = 1'b0;
    stall_decode = 1'b0;
    bubble_exec  = 1'b0;
    flush_fetch  = 1'b0;
    halted       = 1'b0;
    halt_cause   = DBG_OK;
    case (state_q)
      ST_RUN: begin
        if (rst_n) begin
          if (ex_jump_taken) begin
            flush_fetch = 1'b1;
            bubble_exec = 1'b1;
          end else if (hazard) begin
            stall_fetch  = 1'b1;
            stall_decode = 1'b1;
            bubble_exec  = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        stall_fetch  = 1'b1;
        stall_decode = 1'b1;
        bubble_exec  = 1'b1;
      end
      ST_HALTED: begin
        stall_fetch  = 1'b1;
        stall_decode = 1'b1;
        bubble_exec  = 1'b1;
        halted       = 1'b1;
        halt_cause   = cause_q;
      end
      default: ;
    endcase
  end

  // Saturating performance counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_decode && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (flush_fetch && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
    end
  end

  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;

endmodule
